// File: rtl/br_resolve.sv
// Branch resolution: tracks IF/ID/EX branch predictions, resolves in EX,
// drives predictor updates, fetch redirect/flush and saturating perf counters.
module br_resolve #(
    parameter int CNT_W       = 32,
    parameter int s_pc_offset = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_id,
    input  logic             stall_ex,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic             if_br_take,
    input  logic             ex_is_br,
    input  logic             ex_br_en,
    input  logic [31:0]      ex_target,
    input  logic             redirect_ack,
    output logic             update,
    output logic             br_en,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    localparam logic [31:0] PC_INC = 32'd1 << s_pc_offset;

    typedef enum logic {
        IDLE,
        REDIR
    } state_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        pred;
    } trk_t;

    state_t           state_q, state_d;
    trk_t             id_q, id_d;
    trk_t             ex_q, ex_d;
    logic [31:0]      rpc_q, rpc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic             resolve;
    logic             mispredict;

    assign redirect    = (state_q == REDIR);
    assign flush       = (state_q == REDIR);
    assign redirect_pc = rpc_q;
    assign br_cnt      = br_cnt_q;
    assign mis_cnt     = mis_cnt_q;

    always_comb begin
        resolve    = ex_q.v & ex_is_br & ~stall_ex & (state_q == IDLE);
        mispredict = resolve & (ex_q.pred != ex_br_en);
        update     = resolve;
        br_en      = resolve & ex_br_en;

        id_d = id_q;
        if (!stall_id) begin
            id_d = '{v: if_valid, pc: if_pc, pred: if_br_take};
        end
        ex_d = ex_q;
        if (!stall_ex) begin
            ex_d = id_q;
        end
        // Squash wins over a stall so wrong-path work never survives a redirect
        if (flush) begin
            id_d.v = 1'b0;
            ex_d.v = 1'b0;
        end

        state_d = state_q;
        rpc_d   = rpc_q;
        unique case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d = REDIR;
                    rpc_d   = ex_br_en ? ex_target : ex_q.pc + PC_INC;
                end
            end
            REDIR: begin
                if (redirect_ack) begin
                    state_d = IDLE;
                    rpc_d   = '0;
                end
            end
        endcase

        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (resolve && br_cnt_q != '1) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (mispredict && mis_cnt_q != '1) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            id_q      <= '0;
            ex_q      <= '0;
            rpc_q     <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            ex_q      <= ex_d;
            rpc_q     <= rpc_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

endmodule

// File: tb/tb_br_resolve.sv
// Directed testbench for br_resolve: a default-width instance plus a
// CNT_W=4 instance sharing the same stimulus for counter saturation.
module tb_br_resolve;

    logic        clk;
    logic        rst;
    logic        stall_id;
    logic        stall_ex;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_br_take;
    logic        ex_is_br;
    logic        ex_br_en;
    logic [31:0] ex_target;
    logic        redirect_ack;

    logic        update, br_en, redirect, flush;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt, mis_cnt;

    logic        update4, br_en4, redirect4, flush4;
    logic [31:0] redirect_pc4;
    logic [3:0]  br_cnt4, mis_cnt4;

    int checks;
    int failures;
    int exp_br;
    int exp_mis;

    br_resolve dut (
        .clk(clk), .rst(rst), .stall_id(stall_id), .stall_ex(stall_ex),
        .if_valid(if_valid), .if_pc(if_pc), .if_br_take(if_br_take),
        .ex_is_br(ex_is_br), .ex_br_en(ex_br_en), .ex_target(ex_target),
        .redirect_ack(redirect_ack), .update(update), .br_en(br_en),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    br_resolve #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall_id(stall_id), .stall_ex(stall_ex),
        .if_valid(if_valid), .if_pc(if_pc), .if_br_take(if_br_take),
        .ex_is_br(ex_is_br), .ex_br_en(ex_br_en), .ex_target(ex_target),
        .redirect_ack(redirect_ack), .update(update4), .br_en(br_en4),
        .redirect(redirect4), .redirect_pc(redirect_pc4), .flush(flush4),
        .br_cnt(br_cnt4), .mis_cnt(mis_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_br  = 0;
        exp_mis = 0;
    endtask

    // Returns at the negedge where the injected branch sits in EX
    task automatic load_br(input logic [31:0] pc, input logic pred);
        @(negedge clk);
        if_valid   = 1'b1;
        if_pc      = pc;
        if_br_take = pred;
        @(negedge clk);
        if_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ex_is_br = 1'b1;
        ex_br_en = 1'b1;
        if_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (update !== 1'b0 || br_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_update: update=%b br_en=%b want 0 0", update, br_en);
        end
        checks++;
        if (redirect !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_redirect: redirect=%b flush=%b pc=%h want 0 0 0",
                     redirect, flush, redirect_pc);
        end
        checks++;
        if (br_cnt !== 32'd0 || mis_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt: br=%0d mis=%0d want 0 0", br_cnt, mis_cnt);
        end
        ex_is_br = 1'b0;
        ex_br_en = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_br  = 0;
        exp_mis = 0;
    endtask

    task automatic test_correct();
        load_br(32'h100, 1'b1);
        ex_is_br  = 1'b1;
        ex_br_en  = 1'b1;
        ex_target = 32'h500;
        #1;
        checks++;
        if (update !== 1'b1 || br_en !== 1'b1) begin
            failures++;
            $display("FAIL correct_update: update=%b br_en=%b want 1 1", update, br_en);
        end
        exp_br++;
        @(negedge clk);
        #1;
        checks++;
        if (update !== 1'b0 || redirect !== 1'b0 || flush !== 1'b0) begin
            failures++;
            $display("FAIL correct_after: update=%b redirect=%b flush=%b want 0 0 0",
                     update, redirect, flush);
        end
        checks++;
        if (br_cnt !== 32'(exp_br) || mis_cnt !== 32'(exp_mis)) begin
            failures++;
            $display("FAIL correct_cnt: br=%0d mis=%0d want %0d %0d",
                     br_cnt, mis_cnt, exp_br, exp_mis);
        end
        ex_is_br = 1'b0;
        ex_br_en = 1'b0;
    endtask

    task automatic test_taken_mispredict();
        int hi;
        hi = 0;
        load_br(32'h200, 1'b0);
        ex_is_br  = 1'b1;
        ex_br_en  = 1'b1;
        ex_target = 32'h340;
        #1;
        checks++;
        if (update !== 1'b1 || br_en !== 1'b1 || redirect !== 1'b0) begin
            failures++;
            $display("FAIL taken_resolve: update=%b br_en=%b redirect=%b want 1 1 0",
                     update, br_en, redirect);
        end
        exp_br++;
        exp_mis++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ex_is_br = 1'b0;
            #1;
            if (redirect === 1'b1 && flush === 1'b1 && redirect_pc === 32'h340) hi++;
            if (i == 2) redirect_ack = 1'b1;
        end
        @(negedge clk);
        redirect_ack = 1'b0;
        #1;
        checks++;
        if (hi != 3) begin
            failures++;
            $display("FAIL taken_redir_len: cycles=%0d want 3", hi);
        end
        checks++;
        if (redirect !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL taken_release: redirect=%b flush=%b pc=%h want 0 0 0",
                     redirect, flush, redirect_pc);
        end
        checks++;
        if (br_cnt !== 32'(exp_br) || mis_cnt !== 32'(exp_mis)) begin
            failures++;
            $display("FAIL taken_cnt: br=%0d mis=%0d want %0d %0d",
                     br_cnt, mis_cnt, exp_br, exp_mis);
        end
    endtask

    task automatic test_wrap();
        load_br(32'hFFFF_FFFC, 1'b1);
        ex_is_br  = 1'b1;
        ex_br_en  = 1'b0;
        ex_target = 32'h1234_5678;
        #1;
        checks++;
        if (update !== 1'b1 || br_en !== 1'b0) begin
            failures++;
            $display("FAIL wrap_resolve: update=%b br_en=%b want 1 0", update, br_en);
        end
        exp_br++;
        exp_mis++;
        @(negedge clk);
        ex_is_br = 1'b0;
        #1;
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pc: redirect=%b pc=%h want 1 00000000", redirect, redirect_pc);
        end
        redirect_ack = 1'b1;
        @(negedge clk);
        redirect_ack = 1'b0;
        #1;
        checks++;
        if (redirect !== 1'b0 || mis_cnt !== 32'(exp_mis)) begin
            failures++;
            $display("FAIL wrap_release: redirect=%b mis=%0d want 0 %0d",
                     redirect, mis_cnt, exp_mis);
        end
    endtask

    task automatic test_stall();
        int pulses;
        pulses = 0;
        load_br(32'h600, 1'b1);
        stall_ex = 1'b1;
        ex_is_br = 1'b1;
        ex_br_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (update === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (br_cnt !== 32'(exp_br)) begin
            failures++;
            $display("FAIL stall_hold_cnt: br=%0d want %0d", br_cnt, exp_br);
        end
        stall_ex = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (update === 1'b1) pulses++;
            @(negedge clk);
        end
        exp_br++;
        ex_is_br = 1'b0;
        ex_br_en = 1'b0;
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL stall_pulses: got=%0d want 1", pulses);
        end
        checks++;
        if (br_cnt !== 32'(exp_br) || redirect !== 1'b0) begin
            failures++;
            $display("FAIL stall_cnt: br=%0d redirect=%b want %0d 0",
                     br_cnt, redirect, exp_br);
        end
    endtask

    // Mispredict followed by a second branch that reaches EX during REDIR
    task automatic test_back_to_back();
        @(negedge clk);
        if_valid   = 1'b1;
        if_pc      = 32'h400;
        if_br_take = 1'b0;
        @(negedge clk);
        if_pc      = 32'h404;
        if_br_take = 1'b1;
        @(negedge clk);
        if_valid     = 1'b0;
        ex_is_br     = 1'b1;
        ex_br_en     = 1'b1;
        ex_target    = 32'h480;
        redirect_ack = 1'b1;
        #1;
        checks++;
        if (update !== 1'b1 || redirect !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: update=%b redirect=%b want 1 0", update, redirect);
        end
        exp_br++;
        exp_mis++;
        @(negedge clk);
        ex_br_en = 1'b0;
        #1;
        checks++;
        if (redirect !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h480) begin
            failures++;
            $display("FAIL b2b_redir: redirect=%b flush=%b pc=%h want 1 1 00000480",
                     redirect, flush, redirect_pc);
        end
        checks++;
        if (update !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_update: update=%b want 0", update);
        end
        @(negedge clk);
        redirect_ack = 1'b0;
        #1;
        checks++;
        if (redirect !== 1'b0 || flush !== 1'b0 || update !== 1'b0) begin
            failures++;
            $display("FAIL b2b_one_cycle: redirect=%b flush=%b update=%b want 0 0 0",
                     redirect, flush, update);
        end
        checks++;
        if (br_cnt !== 32'(exp_br) || mis_cnt !== 32'(exp_mis)) begin
            failures++;
            $display("FAIL b2b_cnt: br=%0d mis=%0d want %0d %0d",
                     br_cnt, mis_cnt, exp_br, exp_mis);
        end
        ex_is_br = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            load_br(32'h700 + 32'(i * 8), 1'b0);
            ex_is_br  = 1'b1;
            ex_br_en  = 1'b1;
            ex_target = 32'h900;
            @(negedge clk);
            ex_is_br     = 1'b0;
            redirect_ack = 1'b1;
            @(negedge clk);
            redirect_ack = 1'b0;
            exp_br++;
            exp_mis++;
            if (i == 13) begin
                checks++;
                if (br_cnt4 !== 4'd14 || mis_cnt4 !== 4'd14) begin
                    failures++;
                    $display("FAIL sat_mid: br4=%0d mis4=%0d want 14 14", br_cnt4, mis_cnt4);
                end
            end
        end
        #1;
        checks++;
        if (br_cnt4 !== 4'd15 || mis_cnt4 !== 4'd15) begin
            failures++;
            $display("FAIL sat_cnt4: br4=%0d mis4=%0d want 15 15", br_cnt4, mis_cnt4);
        end
        checks++;
        if (br_cnt !== 32'(exp_br) || mis_cnt !== 32'(exp_mis)) begin
            failures++;
            $display("FAIL sat_cnt32: br=%0d mis=%0d want %0d %0d",
                     br_cnt, mis_cnt, exp_br, exp_mis);
        end
    endtask

    task automatic test_reset_mid_redirect();
        load_br(32'h800, 1'b1);
        ex_is_br  = 1'b1;
        ex_br_en  = 1'b0;
        ex_target = 32'hA00;
        @(negedge clk);
        ex_is_br = 1'b0;
        #1;
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h804) begin
            failures++;
            $display("FAIL mid_enter: redirect=%b pc=%h want 1 00000804", redirect, redirect_pc);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (redirect !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL mid_async: redirect=%b flush=%b pc=%h want 0 0 0",
                     redirect, flush, redirect_pc);
        end
        checks++;
        if (br_cnt !== 32'd0 || mis_cnt !== 32'd0) begin
            failures++;
            $display("FAIL mid_cnt: br=%0d mis=%0d want 0 0", br_cnt, mis_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_br  = 0;
        exp_mis = 0;
        load_br(32'hC00, 1'b0);
        ex_is_br = 1'b1;
        ex_br_en = 1'b0;
        #1;
        checks++;
        if (update !== 1'b1 || redirect !== 1'b0) begin
            failures++;
            $display("FAIL mid_next: update=%b redirect=%b want 1 0", update, redirect);
        end
        exp_br++;
        @(negedge clk);
        ex_is_br = 1'b0;
        #1;
        checks++;
        if (redirect !== 1'b0 || br_cnt !== 32'(exp_br) || mis_cnt !== 32'(exp_mis)) begin
            failures++;
            $display("FAIL mid_after: redirect=%b br=%0d mis=%0d want 0 %0d %0d",
                     redirect, br_cnt, mis_cnt, exp_br, exp_mis);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        exp_br       = 0;
        exp_mis      = 0;
        rst          = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        if_valid     = 1'b0;
        if_pc        = 32'h0;
        if_br_take   = 1'b0;
        ex_is_br     = 1'b0;
        ex_br_en     = 1'b0;
        ex_target    = 32'h0;
        redirect_ack = 1'b0;

        test_reset();
        test_correct();
        test_taken_mispredict();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_saturation();
        test_reset_mid_redirect();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/br_resolve.md
BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 Parameter CNT_W, default 32: width of the branch and mispredict performance counters.
REQ-002 Parameter s_pc_offset, default 2: PC increment is 2**s_pc_offset bytes (fall-through = pc + 4).
REQ-003 clk  in  1  single clock; all state is updated on posedge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 stall_id  in  1  hold the ID-stage tracking register.
REQ-006 stall_ex  in  1  hold the EX-stage tracking register and suppress resolution.
REQ-007 if_valid  in  1  IF-stage instruction is valid.
REQ-008 if_pc  in  32  IF-stage PC.
REQ-009 if_br_take  in  1  predictor's taken prediction for if_pc.
REQ-010 ex_is_br  in  1  EX-stage instruction is a conditional branch.
REQ-011 ex_br_en  in  1  actual branch outcome from the EX comparator.
REQ-012 ex_target  in  32  computed branch target.
REQ-013 redirect_ack  in  1  fetch unit accepted redirect_pc.
REQ-014 update  out  1  predictor update strobe.
REQ-015 br_en  out  1  actual outcome forwarded to the predictor, qualified by update.
REQ-016 redirect  out  1  fetch redirect request.
REQ-017 redirect_pc  out  32  corrected fetch PC.
REQ-018 flush  out  1  squash the IF and ID stages.
REQ-019 br_cnt  out  CNT_W  number of resolved branches.
REQ-020 mis_cnt  out  CNT_W  number of mispredicted branches.

Function
REQ-021 Tracking registers hold {valid, pc, pred}: IF->ID loads when !stall_id; ID->EX loads when !stall_ex; a held stage keeps its contents.
REQ-022 When flush=1, the ID register valid and the EX register valid are cleared on the next edge, overriding stalls.
REQ-023 Resolve condition: EX valid & ex_is_br & !stall_ex & state==IDLE.
REQ-024 On a resolve: update=1 and br_en=ex_br_en, combinationally in the same cycle; otherwise update=0 and br_en=0.
REQ-025 A branch held in EX under stall_ex SHALL produce exactly one update, in the first cycle in which stall_ex=0.
REQ-026 Mispredict = resolve & (EX pred != ex_br_en).
REQ-027 FSM states: IDLE and REDIR.
- IDLE -> REDIR on a mispredict.
- REDIR -> IDLE on redirect_ack.
REQ-028 On a mispredict, redirect_pc is registered with ex_target if ex_br_en=1, else EX pc+4 (mod 2^32, wraps).
REQ-029 redirect=1 and flush=1 throughout REDIR; redirect_pc is stable throughout REDIR.
REQ-030 If redirect_ack is asserted in the first REDIR cycle, REDIR lasts exactly one cycle.
REQ-031 redirect_ack in IDLE is ignored.
REQ-032 In REDIR, EX-stage branches are not resolved: no update and no counter change.
REQ-033 br_cnt increments by 1 per resolve; mis_cnt increments by 1 per mispredict; both saturate at all-ones with no wrap.
REQ-034 A correct prediction produces no redirect and no flush.
REQ-035 redirect_pc is zero whenever the FSM is in IDLE.

Reset
REQ-036 rst=0 asynchronously forces the following, regardless of clk:
- FSM to IDLE and all valid bits to 0;
- redirect_pc, br_cnt and mis_cnt to 0;
- redirect=0 and flush=0.
REQ-037 update=0 and br_en=0 while reset is held, because no stage is valid.
REQ-038 Reset asserted in REDIR drops redirect within the same cycle; after release, the FSM resumes in IDLE with no pending redirect.

Verification
REQ-039 Correct prediction: pc=0x100, pred=1, ex_is_br=1, ex_br_en=1 -> update=1 and br_en=1 for one cycle, redirect=0, br_cnt=1, mis_cnt=0.
REQ-040 Taken mispredict: pc=0x200, pred=0, ex_br_en=1, ex_target=0x340, redirect_ack after 3 cycles -> redirect=flush=1 for 3 cycles, redirect_pc=0x340, mis_cnt=1.
REQ-041 Not-taken mispredict at the wrap boundary: pc=0xFFFFFFFC, pred=1, ex_br_en=0 -> redirect_pc=0x00000000.
REQ-042 Stall: branch in EX with stall_ex=1 for 4 cycles, then released -> exactly one update pulse, br_cnt=+1.
REQ-043 Saturation: CNT_W=4, 20 mispredicts each acked -> br_cnt=mis_cnt=15.
REQ-044 Reset mid-redirect: drive rst=0 in REDIR -> redirect and flush drop immediately, counters read 0, and the next correct branch yields update with no redirect.
